// File: rtl/raid_pkg.sv
// rtl/raid_pkg.sv - shared types and helpers for the RAID5 stripe writer
package raid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_FINISH,
        ST_FAULT
    } state_t;

    // 0-based card index (0 = SD1) or stripe role (0 = parity, 1 = sram1, 2 = sram2)
    typedef logic [1:0] sd_index_t;

    localparam int BLOCK_WORDS = 128;

    // Full-width modulo 3. Since 4 == 1 (mod 3), summing the sixteen 2-bit
    // digits keeps the residue and leaves a value of at most 48.
    function automatic sd_index_t mod3(input logic [31:0] n);
        logic [5:0] sum;
        logic [5:0] r;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + {4'b0000, n[2*i +: 2]};
        end
        r = sum % 6'd3;
        return r[1:0];
    endfunction

    // Stripe role carried by a card. A role lands on card (p + role) mod 3,
    // so the role of a card is (card - p) mod 3.
    function automatic sd_index_t card_role(input sd_index_t card, input sd_index_t p);
        logic [2:0] d;
        d = {1'b0, card} + 3'd3 - {1'b0, p};
        if (d >= 3'd3) begin
            d = d - 3'd3;
        end
        return d[1:0];
    endfunction

endpackage

// File: rtl/stripe_fifo.sv
// rtl/stripe_fifo.sv - synchronous stripe buffer holding {sram1, sram2} pairs
// Ports: clk/rst (async active-high), clr (synchronous flush, wins over push/pop),
//        push/push_data, pop/pop_data (head, valid while !empty), full, empty, count.
module stripe_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/stripe_writer.sv
// rtl/stripe_writer.sv - streams one block from two SRAMs to three SD cards with rotated XOR parity
// Ports: start/block_no (block request), sram_read_enable/sram_word_addr/sram1_data/sram2_data
//        (shared SRAM read port, data one cycle after strobe), sd_valid/sd_ready/sd1..3_data
//        (lockstep card stream, accepted only when all three ready), sd_error (card faults),
//        parity_sd_no (1-based parity card), busy/done/error (status to control_unit).
module stripe_writer
    import raid_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       block_no,
    output logic              sram_read_enable,
    output logic [6:0]        sram_word_addr,
    input  logic [WORD_W-1:0] sram1_data,
    input  logic [WORD_W-1:0] sram2_data,
    output logic              sd_valid,
    input  logic [2:0]        sd_ready,
    output logic [WORD_W-1:0] sd1_data,
    output logic [WORD_W-1:0] sd2_data,
    output logic [WORD_W-1:0] sd3_data,
    input  logic [5:0]        sd_error,
    output logic [1:0]        parity_sd_no,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        acc_cnt_q, acc_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        parity_sd_no_q, parity_sd_no_d;
    logic              error_q, error_d;

    logic              fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [2*WORD_W-1:0] fifo_head;
    logic              active, accept;
    logic [CW:0]       used;
    sd_index_t         p;
    logic [WORD_W-1:0] w_sram1, w_sram2, w_parity;

    function automatic logic [WORD_W-1:0] pick(input sd_index_t role,
                                               input logic [WORD_W-1:0] par,
                                               input logic [WORD_W-1:0] s1,
                                               input logic [WORD_W-1:0] s2);
        case (role)
            2'd0:    return par;
            2'd1:    return s1;
            default: return s2;
        endcase
    endfunction

    stripe_fifo #(
        .DATA_W (2*WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data ({sram1_data, sram2_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        active   = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
        // Entries already buffered plus the read whose data lands this cycle;
        // issuing only under this bound means a capture never finds the FIFO full.
        used     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        sd_valid = active && !fifo_empty;
        accept   = sd_valid && (sd_ready == 3'b111);

        state_d          = state_q;
        addr_d           = addr_q;
        acc_cnt_d        = acc_cnt_q;
        parity_sd_no_d   = parity_sd_no_q;
        error_d          = error_q;
        sram_read_enable = 1'b0;
        fifo_clr         = 1'b0;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    state_d        = ST_STREAM;
                    parity_sd_no_d = mod3(block_no) + 2'd1;
                    error_d        = 1'b0;
                    fifo_clr       = 1'b1;
                    addr_d         = '0;
                    acc_cnt_d      = '0;
                end
            end
            ST_STREAM: begin
                sram_read_enable = (used < DEPTH_V);
                if (sram_read_enable) begin
                    addr_d = addr_q + 7'd1;
                    if (addr_q == 7'(BLOCK_WORDS-1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && (acc_cnt_q == 8'(BLOCK_WORDS-1))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            acc_cnt_d = acc_cnt_q + 8'd1;
        end

        // A card fault overrides everything, including a final accept this cycle.
        if (active && (sd_error != 6'd0)) begin
            state_d  = ST_FAULT;
            error_d  = 1'b1;
            fifo_clr = 1'b1;
        end

        inflight_d = sram_read_enable;
        fifo_push  = inflight_q && active && !fifo_full;
        fifo_pop   = accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            acc_cnt_q      <= '0;
            inflight_q     <= 1'b0;
            parity_sd_no_q <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            acc_cnt_q      <= acc_cnt_d;
            inflight_q     <= inflight_d;
            parity_sd_no_q <= parity_sd_no_d;
            error_q        <= error_d;
        end
    end

    assign w_sram1  = fifo_head[2*WORD_W-1:WORD_W];
    assign w_sram2  = fifo_head[WORD_W-1:0];
    assign w_parity = w_sram1 ^ w_sram2;
    assign p        = parity_sd_no_q - 2'd1;

    assign sd1_data = sd_valid ? pick(card_role(2'd0, p), w_parity, w_sram1, w_sram2) : '0;
    assign sd2_data = sd_valid ? pick(card_role(2'd1, p), w_parity, w_sram1, w_sram2) : '0;
    assign sd3_data = sd_valid ? pick(card_role(2'd2, p), w_parity, w_sram1, w_sram2) : '0;

    assign sram_word_addr = addr_q;
    assign parity_sd_no   = parity_sd_no_q;
    assign busy           = active;
    assign done           = (state_q == ST_FINISH);
    assign error          = error_q;

endmodule

// File: tb/tb_stripe_writer.sv
// tb/tb_stripe_writer.sv - self-checking bench for stripe_writer
module tb_stripe_writer;

    localparam int WORD_W = 32;
    localparam int BW     = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       block_no;
    logic              sram_read_enable;
    logic [6:0]        sram_word_addr;
    logic [WORD_W-1:0] sram1_data = '0;
    logic [WORD_W-1:0] sram2_data = '0;
    logic              sd_valid;
    logic [2:0]        sd_ready;
    logic [WORD_W-1:0] sd1_data, sd2_data, sd3_data;
    logic [5:0]        sd_error;
    logic [1:0]        parity_sd_no;
    logic              busy, done, error;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem1 [BW];
    logic [31:0] mem2 [BW];

    stripe_writer #(.WORD_W(WORD_W), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .block_no         (block_no),
        .sram_read_enable (sram_read_enable),
        .sram_word_addr   (sram_word_addr),
        .sram1_data       (sram1_data),
        .sram2_data       (sram2_data),
        .sd_valid         (sd_valid),
        .sd_ready         (sd_ready),
        .sd1_data         (sd1_data),
        .sd2_data         (sd2_data),
        .sd3_data         (sd3_data),
        .sd_error         (sd_error),
        .parity_sd_no     (parity_sd_no),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    // SRAM pair: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        if (sram_read_enable) begin
            sram1_data <= mem1[sram_word_addr];
            sram2_data <= mem2[sram_word_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fill_mem(input int pattern);
        for (int i = 0; i < BW; i++) begin
            case (pattern)
                0: begin mem1[i] = 32'hFFFFFFFF; mem2[i] = 32'h77777777; end
                1: begin mem1[i] = 32'(i);       mem2[i] = 32'h100 + 32'(i); end
                default: begin mem1[i] = $urandom; mem2[i] = $urandom; end
            endcase
        end
    endtask

    // mode: 0 ready always high, 1 random ready, 2 ready=011 for 10 cycles from word 60
    // abort_kind: 0 none, 1 sd_error at word abort_at, 2 rst at word abort_at
    task automatic run_block(input logic [31:0] bn, input logic [1:0] exp_psn, input int mode,
                             input int abort_kind, input int abort_at, input bit extra_start);
        int acc = 0, strobes = 0, first_v = -1, last_acc = -1, done_cyc = -1, done_cnt = 0;
        int busy_drop = -1, bad_addr = 0, bad_word = 0, bad_psn = 0, bad_stall = 0;
        int stall_left = 10, stall_n = 0, p, post_done = 0, err_lost = 0;
        bit aborted = 0, stalling = 0;
        logic [31:0] e [3];
        logic [95:0] held = '0;
        p = int'(bn % 32'd3);
        @(negedge clk);
        start    = 1'b1;
        block_no = bn;
        @(posedge clk);
        for (int k = 1; k < 2000; k++) begin
            @(negedge clk);
            start = (extra_start && k == 5);
            if (start) block_no = bn + 32'd1;

            if (abort_kind == 1 && aborted) begin
                sd_error = 6'd0;
                check("fault_error", error, 1);
                check("fault_valid", sd_valid, 0);
                check("fault_busy", busy, 0);
                check("fault_rd_en", sram_read_enable, 0);
                repeat (10) begin
                    @(negedge clk);
                    if (done) post_done++;
                    if (!error) err_lost++;
                end
                check("fault_no_done", post_done, 0);
                check("fault_error_held", err_lost, 0);
                return;
            end
            if (abort_kind == 2 && acc == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_ctrl_zero", {sd_valid, busy, done, error, sram_read_enable,
                                        sram_word_addr, parity_sd_no}, 0);
                check("rst_data_zero", {sd1_data, sd2_data, sd3_data}, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (abort_kind == 1 && acc == abort_at) begin
                sd_error = 6'b000100;
                aborted  = 1;
            end

            if (mode == 0) sd_ready = 3'b111;
            else if (mode == 1) sd_ready = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
            else begin
                stalling = (acc >= 60 && stall_left > 0);
                sd_ready = stalling ? 3'b011 : 3'b111;
            end

            if (k == 1) check("error_cleared_on_start", error, 0);
            if (sram_read_enable) begin
                if (sram_word_addr != 7'(strobes)) bad_addr++;
                strobes++;
            end
            if (busy && parity_sd_no != exp_psn) bad_psn++;
            if (!busy && busy_drop < 0) busy_drop = k;
            if (mode == 2 && stalling) begin
                if (!sd_valid) bad_stall++;
                if (stall_n > 0 && {sd1_data, sd2_data, sd3_data} != held) bad_stall++;
                if (stall_n >= 4 && sram_read_enable) bad_stall++;
                held = {sd1_data, sd2_data, sd3_data};
                stall_n++;
                stall_left--;
            end
            if (sd_valid && sd_ready == 3'b111) begin
                if (acc < BW) begin
                    e[p]         = mem1[acc] ^ mem2[acc];
                    e[(p+1) % 3] = mem1[acc];
                    e[(p+2) % 3] = mem2[acc];
                    if (sd1_data != e[0] || sd2_data != e[1] || sd3_data != e[2]) bad_word++;
                end
                acc++;
                if (first_v < 0) first_v = k;
                last_acc = k;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        sd_ready = 3'b111;
        check("accepted", acc, BW);
        check("strobes", strobes, BW);
        check("addr_order", bad_addr, 0);
        check("stripe_words", bad_word, 0);
        check("parity_sd_no", bad_psn, 0);
        check("done_pulses", done_cnt, 1);
        if (mode == 0) begin
            check("first_valid_cycle", first_v, 3);
            check("last_accept_cycle", last_acc, 130);
            check("done_cycle", done_cyc, 131);
            check("busy_drop_cycle", busy_drop, 131);
        end
        if (mode == 2) begin
            check("stall_behaviour", bad_stall, 0);
            check("stall_cycles", stall_n, 10);
        end
    endtask

    typedef struct {
        logic [31:0] bn;
        int          pattern;
        int          mode;
        logic [1:0]  exp_psn;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] rbn;
        vecs[0] = '{32'd0,        0, 0, 2'd1};
        vecs[1] = '{32'd4,        1, 0, 2'd2};
        vecs[2] = '{32'hFFFFFFFF, 2, 0, 2'd1};
        vecs[3] = '{32'd5,        1, 0, 2'd3};
        vecs[4] = '{32'h80000000, 2, 1, 2'd3};
        vecs[5] = '{32'hFFFFFFFE, 0, 1, 2'd3};
        vecs[6] = '{32'd7,        2, 0, 2'd2};

        rst      = 1'b1;
        start    = 1'b0;
        block_no = '0;
        sd_ready = '0;
        sd_error = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_sd_valid", sd_valid, 0);
        check("reset_rd_en", sram_read_enable, 0);
        check("reset_psn", parity_sd_no, 0);
        check("reset_data", {sd1_data, sd2_data, sd3_data}, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill_mem(vecs[v].pattern);
            run_block(vecs[v].bn, vecs[v].exp_psn, vecs[v].mode, 0, 0, 0);
        end

        fill_mem(1);
        run_block(32'd10, 2'd2, 2, 0, 0, 0);

        fill_mem(2);
        run_block(32'd8, 2'd3, 0, 1, 50, 0);
        run_block(32'd9, 2'd1, 0, 0, 0, 0);

        fill_mem(2);
        run_block(32'd11, 2'd3, 0, 2, 70, 0);
        run_block(32'd12, 2'd1, 0, 0, 0, 1);

        for (int r = 0; r < 4; r++) begin
            rbn = $urandom;
            fill_mem(2);
            run_block(rbn, 2'(rbn % 32'd3) + 2'd1, 1, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
